// File: rtl/execute_stage_pkg.sv
// Shared encodings for the EX stage: MIPS opcode/funct values, decoder
// control enums and the MD-class instruction classifier.
package execute_stage_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    typedef enum logic { IMM_SIGN, IMM_ZERO } imm_mode_e;
    typedef enum logic { SRC_B_RT, SRC_B_IMM } src_b_e;
    typedef enum logic [1:0] { AO_ALU, AO_HI, AO_LO } ao_sel_e;
    typedef enum logic [2:0] { MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU } md_op_e;
    typedef enum logic { MDU_IDLE, MDU_BUSY } mdu_state_e;

    function automatic logic inst_is_md(input logic [31:0] inst);
        return (inst[31:26] == OP_SPECIAL) &&
               (inst[5:0] == FN_MULT || inst[5:0] == FN_MULTU ||
                inst[5:0] == FN_DIV  || inst[5:0] == FN_DIVU);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// EX stage bus: instruction/operands in, ALU/memory results and MDU status out.
interface execute_stage_if;
    logic [31:0] Inst;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        flush;
    logic [31:0] Inst_out;
    logic [31:0] AO_out;
    logic [31:0] rt_out;
    logic        md_start;
    logic        md_busy;
    logic        overflow_exception;

    modport master (
        output Inst, rs, rt, flush,
        input  Inst_out, AO_out, rt_out, md_start, md_busy, overflow_exception
    );

    modport slave (
        input  Inst, rs, rt, flush,
        output Inst_out, AO_out, rt_out, md_start, md_busy, overflow_exception
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at
// start, held in pending registers and committed when the busy count expires.
module mult_div_unit
    import execute_stage_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);
    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi, pend_lo;
    logic [31:0]      res_hi, res_lo;
    logic             accept;
    logic             is_mul;
    logic [63:0]      prod_s, prod_u;
    logic [31:0]      mag_a, mag_b, quo_m, rem_m;

    assign busy   = (state == MDU_BUSY);
    assign accept = start & ~busy & ~flush;
    assign is_mul = (op == MD_MULT) || (op == MD_MULTU);

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide via magnitudes so the most-negative dividend is handled exactly.
    assign mag_a = a[31] ? -a : a;
    assign mag_b = b[31] ? -b : b;
    assign quo_m = (mag_b == '0) ? '0 : mag_a / mag_b;
    assign rem_m = (mag_b == '0) ? '0 : mag_a % mag_b;

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                if (b != '0) begin
                    res_lo = (a[31] ^ b[31]) ? -quo_m : quo_m;
                    res_hi = a[31] ? -rem_m : rem_m;
                end
            end
            MD_DIVU: begin
                if (b != '0) begin
                    res_lo = a / b;
                    res_hi = a % b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= MDU_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MDU_IDLE: if (accept) state_next = MDU_BUSY;
            MDU_BUSY: if (cnt == CNT_W'(1)) state_next = MDU_IDLE;
            default:  state_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            cnt     <= '0;
        end else if (accept) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (busy) begin
            // mthi/mtlo while busy are dropped; the pending commit wins.
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (!flush) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Pipeline EX stage: inline decoder, combinational ALU with overflow
// detection, and the multi-cycle MDU feeding HI/LO.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic           clk,
    input logic           reset,
    execute_stage_if.slave ex
);
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt, shamt_val;
    logic [15:0] imm;

    alu_op_e   alu_op;
    imm_mode_e imm_mode;
    src_b_e    src_b;
    ao_sel_e   ao_sel;
    md_op_e    md_op;
    logic      ov_check, shift_var, hi_we, lo_we;

    logic [31:0] imm_ext, src_b_val, alu_res, hi, lo;
    logic [32:0] sum33, diff33;
    logic        md_busy;

    assign opcode = ex.Inst[31:26];
    assign funct  = ex.Inst[5:0];
    assign shamt  = ex.Inst[10:6];
    assign imm    = ex.Inst[15:0];

    always_comb begin
        alu_op    = ALU_ADD;
        imm_mode  = IMM_SIGN;
        src_b     = SRC_B_RT;
        ao_sel    = AO_ALU;
        md_op     = MD_NONE;
        ov_check  = 1'b0;
        shift_var = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_SLL:   alu_op = ALU_SLL;
                    FN_SRL:   alu_op = ALU_SRL;
                    FN_SRA:   alu_op = ALU_SRA;
                    FN_SLLV:  begin alu_op = ALU_SLL; shift_var = 1'b1; end
                    FN_SRLV:  begin alu_op = ALU_SRL; shift_var = 1'b1; end
                    FN_SRAV:  begin alu_op = ALU_SRA; shift_var = 1'b1; end
                    FN_MFHI:  ao_sel = AO_HI;
                    FN_MFLO:  ao_sel = AO_LO;
                    FN_MTHI:  hi_we = 1'b1;
                    FN_MTLO:  lo_we = 1'b1;
                    FN_MULT:  md_op = MD_MULT;
                    FN_MULTU: md_op = MD_MULTU;
                    FN_DIV:   md_op = MD_DIV;
                    FN_DIVU:  md_op = MD_DIVU;
                    FN_ADD:   ov_check = 1'b1;
                    FN_ADDU:  alu_op = ALU_ADD;
                    FN_SUB:   begin alu_op = ALU_SUB; ov_check = 1'b1; end
                    FN_SUBU:  alu_op = ALU_SUB;
                    FN_AND:   alu_op = ALU_AND;
                    FN_OR:    alu_op = ALU_OR;
                    FN_XOR:   alu_op = ALU_XOR;
                    FN_NOR:   alu_op = ALU_NOR;
                    FN_SLT:   alu_op = ALU_SLT;
                    FN_SLTU:  alu_op = ALU_SLTU;
                    default:  ;
                endcase
            end
            OP_ADDI:  begin src_b = SRC_B_IMM; ov_check = 1'b1; end
            OP_ADDIU: src_b = SRC_B_IMM;
            OP_SLTI:  begin src_b = SRC_B_IMM; alu_op = ALU_SLT; end
            OP_SLTIU: begin src_b = SRC_B_IMM; alu_op = ALU_SLTU; end
            OP_ANDI:  begin src_b = SRC_B_IMM; imm_mode = IMM_ZERO; alu_op = ALU_AND; end
            OP_ORI:   begin src_b = SRC_B_IMM; imm_mode = IMM_ZERO; alu_op = ALU_OR; end
            OP_XORI:  begin src_b = SRC_B_IMM; imm_mode = IMM_ZERO; alu_op = ALU_XOR; end
            OP_LUI:   alu_op = ALU_LUI;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: src_b = SRC_B_IMM;
            default: ;
        endcase
    end

    assign imm_ext   = (imm_mode == IMM_ZERO) ? {16'b0, imm} : {{16{imm[15]}}, imm};
    assign src_b_val = (src_b == SRC_B_IMM) ? imm_ext : ex.rt;
    assign shamt_val = shift_var ? ex.rs[4:0] : shamt;
    assign sum33     = {ex.rs[31], ex.rs} + {src_b_val[31], src_b_val};
    assign diff33    = {ex.rs[31], ex.rs} - {src_b_val[31], src_b_val};

    always_comb begin
        alu_res = sum33[31:0];
        case (alu_op)
            ALU_ADD:  alu_res = sum33[31:0];
            ALU_SUB:  alu_res = diff33[31:0];
            ALU_AND:  alu_res = ex.rs & src_b_val;
            ALU_OR:   alu_res = ex.rs | src_b_val;
            ALU_XOR:  alu_res = ex.rs ^ src_b_val;
            ALU_NOR:  alu_res = ~(ex.rs | src_b_val);
            ALU_SLT:  alu_res = {31'b0, $signed(ex.rs) < $signed(src_b_val)};
            ALU_SLTU: alu_res = {31'b0, ex.rs < src_b_val};
            ALU_SLL:  alu_res = ex.rt << shamt_val;
            ALU_SRL:  alu_res = ex.rt >> shamt_val;
            ALU_SRA:  alu_res = $unsigned($signed(ex.rt) >>> shamt_val);
            ALU_LUI:  alu_res = {imm, 16'b0};
            default:  ;
        endcase
    end

    always_comb begin
        ex.AO_out = alu_res;
        case (ao_sel)
            AO_HI:   ex.AO_out = hi;
            AO_LO:   ex.AO_out = lo;
            default: ;
        endcase
    end

    assign ex.overflow_exception = ov_check &
        ((alu_op == ALU_SUB) ? (diff33[32] ^ diff33[31]) : (sum33[32] ^ sum33[31]));
    assign ex.Inst_out = ex.Inst;
    assign ex.rt_out   = ex.rt;
    assign ex.md_busy  = md_busy;
    assign ex.md_start = (md_op != MD_NONE) & ~md_busy & ~ex.flush;

    mult_div_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdu (
        .clk  (clk),
        .reset(reset),
        .op   (md_op),
        .a    (ex.rs),
        .b    (ex.rt),
        .start(md_op != MD_NONE),
        .flush(ex.flush),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .wdata(ex.rs),
        .hi   (hi),
        .lo   (lo),
        .busy (md_busy)
    );

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized bench for execute_stage against a behavioural
// model of the ALU and of HI/LO timing.
module tb_execute_stage;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [31:0] I_NOP   = 32'h0000_0000;
    localparam logic [31:0] I_MFHI  = 32'h0000_0010;
    localparam logic [31:0] I_MTHI  = 32'h0000_0011;
    localparam logic [31:0] I_MFLO  = 32'h0000_0012;
    localparam logic [31:0] I_MULT  = 32'h0000_0018;
    localparam logic [31:0] I_MULTU = 32'h0000_0019;
    localparam logic [31:0] I_DIV   = 32'h0000_001A;
    localparam logic [31:0] I_DIVU  = 32'h0000_001B;
    localparam logic [31:0] I_ADD   = 32'h0000_0020;
    localparam logic [31:0] I_ADDU  = 32'h0000_0021;
    localparam logic [31:0] I_SW    = 32'hAC00_FFFC;
    localparam logic [31:0] I_ORI   = 32'h3400_8000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    execute_stage_if ex_bus();

    execute_stage #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ex   (ex_bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: HI/LO, pending result and the cycle window [op_start+1, op_end) of busy.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_valid;
    int          cyc, op_start, op_end;
    logic        act_start, act_mthi, act_mtlo;
    logic [5:0]  act_fn;
    logic [31:0] act_rs, act_rt;

    logic [5:0] r_fns [24] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11,
                               6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21,
                               6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [5:0] i_ops [16] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                               6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic bit is_md(input logic [31:0] inst);
        return inst[31:26] == 6'h00 && inst[5:0] >= 6'h18 && inst[5:0] <= 6'h1B;
    endfunction

    function automatic bit model_busy();
        return (cyc > op_start) && (cyc < op_end);
    endfunction

    task automatic model_reset();
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_valid = 1'b0;
        op_start = 0; op_end = 0;
    endtask

    function automatic void ref_alu(input logic [31:0] inst, rs, rt, hi, lo,
                                    output logic [31:0] ao, output logic ov, output logic chk);
        logic [5:0]  op, fn;
        logic [4:0]  sh;
        logic [31:0] se, ze;
        longint      s;
        op = inst[31:26]; fn = inst[5:0]; sh = inst[10:6];
        se = {{16{inst[15]}}, inst[15:0]};
        ze = {16'h0000, inst[15:0]};
        ao = rs + rt; ov = 1'b0; chk = 1'b1;
        if (op == 6'h00) begin
            case (fn)
                6'h00: ao = rt << sh;
                6'h02: ao = rt >> sh;
                6'h03: ao = $unsigned($signed(rt) >>> sh);
                6'h04: ao = rt << rs[4:0];
                6'h06: ao = rt >> rs[4:0];
                6'h07: ao = $unsigned($signed(rt) >>> rs[4:0]);
                6'h10: ao = hi;
                6'h12: ao = lo;
                6'h20, 6'h22: begin
                    s = (fn == 6'h20) ? longint'($signed(rs)) + longint'($signed(rt))
                                      : longint'($signed(rs)) - longint'($signed(rt));
                    ao = s[31:0];
                    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                6'h21: ao = rs + rt;
                6'h23: ao = rs - rt;
                6'h24: ao = rs & rt;
                6'h25: ao = rs | rt;
                6'h26: ao = rs ^ rt;
                6'h27: ao = ~(rs | rt);
                6'h2A: ao = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                6'h2B: ao = (rs < rt) ? 32'd1 : 32'd0;
                default: chk = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08: begin
                    s = longint'($signed(rs)) + longint'($signed(se));
                    ao = s[31:0];
                    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                6'h09: ao = rs + se;
                6'h0A: ao = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
                6'h0B: ao = (rs < se) ? 32'd1 : 32'd0;
                6'h0C: ao = rs & ze;
                6'h0D: ao = rs | ze;
                6'h0E: ao = rs ^ ze;
                6'h0F: ao = {inst[15:0], 16'h0000};
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: ao = rs + se;
                default: chk = 1'b0;
            endcase
        end
    endfunction

    function automatic logic [63:0] ref_md(input logic [5:0] fn, input logic [31:0] rs, rt);
        longint      sq, sr;
        logic [63:0] ua, ub;
        ua = {32'h0, rs};
        ub = {32'h0, rt};
        case (fn)
            6'h18: return longint'($signed(rs)) * longint'($signed(rt));
            6'h19: return ua * ub;
            6'h1A: begin
                sq = longint'($signed(rs)) / longint'($signed(rt));
                sr = longint'($signed(rs)) % longint'($signed(rt));
                return {sr[31:0], sq[31:0]};
            end
            default: return {rs % rt, rs / rt};
        endcase
    endfunction

    task automatic drive(input logic [31:0] inst, rs, rt, input logic fl);
        logic [31:0] ao;
        logic        ov, chk, busy_exp, start_exp;
        ex_bus.Inst = inst; ex_bus.rs = rs; ex_bus.rt = rt; ex_bus.flush = fl;
        #1;
        assert (!(is_md(inst) && model_busy())) else $error("hazard: MD instruction in EX while busy");
        busy_exp  = model_busy();
        start_exp = is_md(inst) && !busy_exp && !fl;
        ref_alu(inst, rs, rt, m_hi, m_lo, ao, ov, chk);
        check32("inst_out", ex_bus.Inst_out, inst);
        check32("rt_out", ex_bus.rt_out, rt);
        if (chk) check32("ao_out", ex_bus.AO_out, ao);
        check1("overflow", ex_bus.overflow_exception, ov);
        check1("md_start", ex_bus.md_start, start_exp);
        check1("md_busy", ex_bus.md_busy, busy_exp);
        act_start = start_exp && reset;
        act_mthi  = inst[31:26] == 6'h00 && inst[5:0] == 6'h11 && !busy_exp && !fl && reset;
        act_mtlo  = inst[31:26] == 6'h00 && inst[5:0] == 6'h13 && !busy_exp && !fl && reset;
        act_fn = inst[5:0]; act_rs = rs; act_rt = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) begin
            model_reset();
        end else begin
            if (p_valid && cyc + 1 == op_end) begin
                m_hi = p_hi; m_lo = p_lo; p_valid = 1'b0;
            end
            if (act_mthi) m_hi = act_rs;
            if (act_mtlo) m_lo = act_rs;
            if (act_start) begin
                op_start = cyc;
                op_end   = cyc + 1 + ((act_fn == 6'h18 || act_fn == 6'h19) ? MULT_N : DIV_N);
                p_valid  = !(act_fn >= 6'h1A && act_rt == '0);
                {p_hi, p_lo} = ref_md(act_fn, act_rs, act_rt);
            end
            cyc++;
        end
        act_start = 1'b0; act_mthi = 1'b0; act_mtlo = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            drive(I_NOP, 32'h0, 32'h0, 1'b0);
            if (!ex_bus.md_busy) break;
            n++;
            tick();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0;
        cyc = 0;
        act_start = 1'b0; act_mthi = 1'b0; act_mtlo = 1'b0;
        act_fn = '0; act_rs = '0; act_rt = '0;
        model_reset();

        drive(I_MFHI, 32'h0, 32'h0, 1'b0);
        check1("reset_busy", ex_bus.md_busy, 1'b0);
        check32("reset_hi", ex_bus.AO_out, 32'h0);
        drive(I_MFLO, 32'h0, 32'h0, 1'b0);
        check32("reset_lo", ex_bus.AO_out, 32'h0);
        tick();
        reset = 1'b1;

        drive(I_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check1("mult_start", ex_bus.md_start, 1'b1);
        tick();
        busy_len(n);
        check32("mult_busy_len", 32'(n), 32'(MULT_N));
        drive(I_MFHI, 32'h0, 32'h0, 1'b0);
        check32("mult_hi", ex_bus.AO_out, 32'hFFFF_FFFF);
        tick();
        drive(I_MFLO, 32'h0, 32'h0, 1'b0);
        check32("mult_lo", ex_bus.AO_out, 32'hFFFF_FFFA);
        tick();

        drive(I_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        tick();
        busy_len(n);
        drive(I_MFHI, 32'h0, 32'h0, 1'b0);
        check32("multu_hi", ex_bus.AO_out, 32'h0000_0002);
        tick();
        drive(I_MFLO, 32'h0, 32'h0, 1'b0);
        check32("multu_lo", ex_bus.AO_out, 32'hFFFF_FFFA);
        tick();

        drive(I_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        tick();
        busy_len(n);
        check32("div_busy_len", 32'(n), 32'(DIV_N));
        drive(I_MFLO, 32'h0, 32'h0, 1'b0);
        check32("div_lo", ex_bus.AO_out, 32'hFFFF_FFFD);
        tick();
        drive(I_MFHI, 32'h0, 32'h0, 1'b0);
        check32("div_hi", ex_bus.AO_out, 32'hFFFF_FFFF);
        tick();

        drive(I_DIVU, 32'd5, 32'd0, 1'b0);
        tick();
        busy_len(n);
        check32("divu0_busy_len", 32'(n), 32'(DIV_N));
        drive(I_MFLO, 32'h0, 32'h0, 1'b0);
        check32("divu0_lo", ex_bus.AO_out, 32'hFFFF_FFFD);
        tick();
        drive(I_MFHI, 32'h0, 32'h0, 1'b0);
        check32("divu0_hi", ex_bus.AO_out, 32'hFFFF_FFFF);
        tick();

        drive(I_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
        check32("add_ao", ex_bus.AO_out, 32'h8000_0000);
        check1("add_ov", ex_bus.overflow_exception, 1'b1);
        tick();
        drive(I_ADDU, 32'h7FFF_FFFF, 32'd1, 1'b0);
        check1("addu_ov", ex_bus.overflow_exception, 1'b0);
        tick();

        drive(I_SW, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
        check32("sw_addr", ex_bus.AO_out, 32'h0000_0FFC);
        check32("sw_data", ex_bus.rt_out, 32'hDEAD_BEEF);
        tick();
        drive(I_ORI, 32'h0, 32'h0, 1'b0);
        check32("ori_zext", ex_bus.AO_out, 32'h0000_8000);
        tick();

        drive(I_MULT, 32'd5, 32'd7, 1'b1);
        check1("flush_no_start", ex_bus.md_start, 1'b0);
        tick();
        drive(I_NOP, 32'h0, 32'h0, 1'b0);
        check1("flush_no_busy", ex_bus.md_busy, 1'b0);
        tick();

        drive(I_MULT, 32'd5, 32'd7, 1'b0);
        tick();
        for (int i = 1; i <= MULT_N; i++) begin
            drive(I_NOP, 32'h0, 32'h0, i == 3);
            check1("flush_busy", ex_bus.md_busy, 1'b1);
            tick();
        end
        drive(I_MFLO, 32'h0, 32'h0, 1'b0);
        check32("flush_commit_lo", ex_bus.AO_out, 32'd35);
        tick();

        drive(I_DIV, 32'd100, 32'd7, 1'b0);
        tick();
        drive(I_NOP, 32'h0, 32'h0, 1'b0);
        tick();
        drive(I_NOP, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        #1;
        model_reset();
        check1("async_reset_busy", ex_bus.md_busy, 1'b0);
        drive(I_MFHI, 32'h0, 32'h0, 1'b0);
        check32("async_reset_hi", ex_bus.AO_out, 32'h0);
        drive(I_MFLO, 32'h0, 32'h0, 1'b0);
        check32("async_reset_lo", ex_bus.AO_out, 32'h0);
        tick();
        reset = 1'b1;
        drive(I_MTHI, 32'h0000_1234, 32'h0, 1'b0);
        tick();
        drive(I_MFHI, 32'h0, 32'h0, 1'b0);
        check32("mthi_after_reset", ex_bus.AO_out, 32'h0000_1234);
        tick();

        for (int i = 0; i < 400; i++) begin
            logic [31:0] inst;
            int          sel;
            inst = $urandom;
            sel  = int'($urandom_range(0, 39));
            if (sel < 24) begin
                inst[31:26] = 6'h00;
                inst[5:0]   = r_fns[sel];
            end else begin
                inst[31:26] = i_ops[sel - 24];
            end
            if (is_md(inst) && model_busy()) inst[5:0] = 6'h21;
            drive(inst, pick(), pick(), $urandom_range(0, 9) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
